wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 162 ++++++++++++++++
 tb/tb_wb_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter: ALU results take priority, load results are
// bypassed when possible or buffered in a small FIFO with a starvation guard.
`ifndef XLEN
`define XLEN 32
`endif

module wb_arbiter #(
   parameter int unsigned FIFO_DEPTH   = 2,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_alu_valid,
   input  logic [4:0]        i_alu_rd,
   input  logic [`XLEN-1:0]  i_alu_data,
   input  logic              i_lsu_valid,
   output logic              o_lsu_ready,
   input  logic [4:0]        i_lsu_rd,
   input  logic [`XLEN-1:0]  i_lsu_data,
   output logic              o_alu_stall,
   output logic [31:0]       o_pending,
   output logic              o_Wen,
   output logic [4:0]        o_Wnum,
   output logic [`XLEN-1:0]  o_Wd
);

   localparam int unsigned XW    = `XLEN;
   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned STV_W = 4;

   logic [4:0]            rd_mem_q   [FIFO_DEPTH];
   logic [XW-1:0]         data_mem_q [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] valid_q, valid_d;
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic [STV_W-1:0]      starve_q, starve_d;
   logic                  stall_q, stall_d;
   logic                  ready_q, ready_d;
   logic [31:0]           pending_q, pending_d;
   logic                  wen_q, wen_d;
   logic [4:0]            wnum_q, wnum_d;
   logic [XW-1:0]         wd_q, wd_d;

   logic                  alu_sel, fifo_nempty, lsu_hs, lsu_nz;
   logic                  pop, push, bypass;
   logic [4:0]            entry_rd;

   // Per-cycle source selection: ALU, then FIFO head, then direct LSU bypass.
   always_comb begin
      alu_sel     = i_alu_valid && (i_alu_rd != 5'd0);
      fifo_nempty = (count_q != '0);
      lsu_hs      = i_lsu_valid && ready_q;
      lsu_nz      = (i_lsu_rd != 5'd0);
      pop         = !alu_sel && fifo_nempty;
      bypass      = !alu_sel && !fifo_nempty && lsu_hs && lsu_nz;
      push        = lsu_hs && lsu_nz && !bypass;
   end

   // FIFO bookkeeping, starvation counter and registered write port.
   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      valid_d   = valid_q;
      starve_d  = '0;
      stall_d   = 1'b0;
      ready_d   = 1'b0;
      pending_d = '0;
      entry_rd  = '0;
      wen_d     = 1'b0;
      wnum_d    = '0;
      wd_d      = '0;

      if (push) begin
         wr_ptr_d          = wr_ptr_q + PTR_W'(1);
         valid_d[wr_ptr_q] = 1'b1;
      end
      if (pop) begin
         rd_ptr_d          = rd_ptr_q + PTR_W'(1);
         valid_d[rd_ptr_q] = 1'b0;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
      ready_d = (count_d < CNT_W'(FIFO_DEPTH));

      // Pending mask reflects the entries valid after this edge, including a push.
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
         entry_rd = (push && (wr_ptr_q == PTR_W'(i))) ? i_lsu_rd : rd_mem_q[i];
         if (valid_d[i]) begin
            pending_d = pending_d | (32'd1 << entry_rd);
         end
      end
      pending_d[0] = 1'b0;

      if (fifo_nempty && !pop) begin
         starve_d = (starve_q == 4'hF) ? starve_q : starve_q + STV_W'(1);
      end
      stall_d = (starve_q == STV_W'(STARVE_LIMIT)) && !stall_q;

      if (alu_sel) begin
         wen_d  = 1'b1;
         wnum_d = i_alu_rd;
         wd_d   = i_alu_data;
      end else if (pop) begin
         wen_d  = 1'b1;
         wnum_d = rd_mem_q[rd_ptr_q];
         wd_d   = data_mem_q[rd_ptr_q];
      end else if (bypass) begin
         wen_d  = 1'b1;
         wnum_d = i_lsu_rd;
         wd_d   = i_lsu_data;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         valid_q   <= '0;
         starve_q  <= '0;
         stall_q   <= 1'b0;
         ready_q   <= 1'b0;
         pending_q <= '0;
         wen_q     <= 1'b0;
         wnum_q    <= '0;
         wd_q      <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         valid_q   <= valid_d;
         starve_q  <= starve_d;
         stall_q   <= stall_d;
         ready_q   <= ready_d;
         pending_q <= pending_d;
         wen_q     <= wen_d;
         wnum_q    <= wnum_d;
         wd_q      <= wd_d;
      end
   end

   // Payload storage needs no reset; occupancy is tracked by valid_q/count_q.
   always_ff @(posedge i_clk) begin
      if (push) begin
         rd_mem_q[wr_ptr_q]   <= i_lsu_rd;
         data_mem_q[wr_ptr_q] <= i_lsu_data;
      end
   end

   assign o_lsu_ready = ready_q;
   assign o_alu_stall = stall_q;
   assign o_pending   = pending_q;
   assign o_Wen       = wen_q;
   assign o_Wnum      = wnum_q;
   assign o_Wd        = wd_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: reset, ALU path, bypass, collision, full FIFO,
// starvation stall and asynchronous reset with buffered entries.
`ifndef XLEN
`define XLEN 32
`endif

module tb_wb_arbiter;

   localparam int XW = `XLEN;

   logic          clk;
   logic          rst;
   logic          alu_valid;
   logic [4:0]    alu_rd;
   logic [XW-1:0] alu_data;
   logic          lsu_valid;
   logic          lsu_ready;
   logic [4:0]    lsu_rd;
   logic [XW-1:0] lsu_data;
   logic          alu_stall;
   logic [31:0]   pending;
   logic          wen;
   logic [4:0]    wnum;
   logic [XW-1:0] wd;

   int checks;
   int failures;

   wb_arbiter #(.FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_alu_valid (alu_valid),
      .i_alu_rd    (alu_rd),
      .i_alu_data  (alu_data),
      .i_lsu_valid (lsu_valid),
      .o_lsu_ready (lsu_ready),
      .i_lsu_rd    (lsu_rd),
      .i_lsu_data  (lsu_data),
      .o_alu_stall (alu_stall),
      .o_pending   (pending),
      .o_Wen       (wen),
      .o_Wnum      (wnum),
      .o_Wd        (wd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      alu_valid = 1'b0;
      alu_rd    = '0;
      alu_data  = '0;
      lsu_valid = 1'b0;
      lsu_rd    = '0;
      lsu_data  = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle();
      tick();
      tick();
      checks++; if (wen !== 1'b0) begin failures++; $display("FAIL rst_wen got=%0h exp=0", wen); end
      checks++; if (wnum !== 5'd0) begin failures++; $display("FAIL rst_wnum got=%0h exp=0", wnum); end
      checks++; if (wd !== XW'(0)) begin failures++; $display("FAIL rst_wd got=%0h exp=0", wd); end
      checks++; if (pending !== 32'h0) begin failures++; $display("FAIL rst_pending got=%0h exp=0", pending); end
      checks++; if (lsu_ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%0h exp=0", lsu_ready); end
      checks++; if (alu_stall !== 1'b0) begin failures++; $display("FAIL rst_stall got=%0h exp=0", alu_stall); end
      rst = 1'b0;
      tick();
      checks++; if (lsu_ready !== 1'b1) begin failures++; $display("FAIL post_rst_ready got=%0h exp=1", lsu_ready); end
      checks++; if (wen !== 1'b0) begin failures++; $display("FAIL post_rst_wen got=%0h exp=0", wen); end
   endtask

   task automatic test_alu_only();
      alu_valid = 1'b1; alu_rd = 5'd5; alu_data = XW'(32'hDEADBEEF);
      tick();
      checks++; if (wen !== 1'b1) begin failures++; $display("FAIL alu_wen got=%0h exp=1", wen); end
      checks++; if (wnum !== 5'd5) begin failures++; $display("FAIL alu_wnum got=%0h exp=5", wnum); end
      checks++; if (wd !== XW'(32'hDEADBEEF)) begin failures++; $display("FAIL alu_wd got=%0h exp=deadbeef", wd); end
      idle();
      tick();
      checks++; if (wen !== 1'b0) begin failures++; $display("FAIL alu_idle_wen got=%0h exp=0", wen); end
   endtask

   task automatic test_x0();
      alu_valid = 1'b1; alu_rd = 5'd0; alu_data = XW'(32'h55);
      tick();
      checks++; if (wen !== 1'b0) begin failures++; $display("FAIL alu_x0_wen got=%0h exp=0", wen); end
      idle();
      lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = XW'(32'h66);
      tick();
      checks++; if (wen !== 1'b0) begin failures++; $display("FAIL lsu_x0_wen got=%0h exp=0", wen); end
      checks++; if (pending !== 32'h0) begin failures++; $display("FAIL lsu_x0_pending got=%0h exp=0", pending); end
      checks++; if (lsu_ready !== 1'b1) begin failures++; $display("FAIL lsu_x0_ready got=%0h exp=1", lsu_ready); end
      idle();
      tick();
      checks++; if (wen !== 1'b0) begin failures++; $display("FAIL lsu_x0_late_wen got=%0h exp=0", wen); end
   endtask

   task automatic test_bypass();
      lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = XW'(32'h12);
      tick();
      checks++; if (wen !== 1'b1) begin failures++; $display("FAIL byp_wen got=%0h exp=1", wen); end
      checks++; if (wnum !== 5'd7) begin failures++; $display("FAIL byp_wnum got=%0h exp=7", wnum); end
      checks++; if (wd !== XW'(32'h12)) begin failures++; $display("FAIL byp_wd got=%0h exp=12", wd); end
      checks++; if (pending !== 32'h0) begin failures++; $display("FAIL byp_pending got=%0h exp=0", pending); end
      idle();
      tick();
      checks++; if (wen !== 1'b0) begin failures++; $display("FAIL byp_idle_wen got=%0h exp=0", wen); end
   endtask

   task automatic test_collision();
      alu_valid = 1'b1; alu_rd = 5'd3; alu_data = XW'(32'hA3);
      lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = XW'(32'h99);
      tick();
      checks++; if (wen !== 1'b1 || wnum !== 5'd3) begin failures++; $display("FAIL col1_write got=%0h/%0h exp=1/3", wen, wnum); end
      checks++; if (wd !== XW'(32'hA3)) begin failures++; $display("FAIL col1_wd got=%0h exp=a3", wd); end
      checks++; if (pending !== 32'h0000_0200) begin failures++; $display("FAIL col1_pending got=%0h exp=200", pending); end
      idle();
      tick();
      checks++; if (wen !== 1'b1 || wnum !== 5'd9) begin failures++; $display("FAIL col2_write got=%0h/%0h exp=1/9", wen, wnum); end
      checks++; if (wd !== XW'(32'h99)) begin failures++; $display("FAIL col2_wd got=%0h exp=99", wd); end
      checks++; if (pending !== 32'h0) begin failures++; $display("FAIL col2_pending got=%0h exp=0", pending); end
      tick();
      checks++; if (wen !== 1'b0) begin failures++; $display("FAIL col3_wen got=%0h exp=0", wen); end
   endtask

   task automatic test_full();
      alu_valid = 1'b1; alu_rd = 5'd1; alu_data = XW'(32'h101);
      lsu_valid = 1'b1; lsu_rd = 5'd10; lsu_data = XW'(32'hA0);
      tick();
      checks++; if (wnum !== 5'd1 || lsu_ready !== 1'b1) begin failures++; $display("FAIL full0 got wnum=%0h rdy=%0h exp 1/1", wnum, lsu_ready); end
      alu_rd = 5'd2; alu_data = XW'(32'h102);
      lsu_rd = 5'd11; lsu_data = XW'(32'hB0);
      tick();
      checks++; if (wnum !== 5'd2 || wen !== 1'b1) begin failures++; $display("FAIL full1_write got=%0h/%0h exp=1/2", wen, wnum); end
      checks++; if (lsu_ready !== 1'b0) begin failures++; $display("FAIL full1_ready got=%0h exp=0", lsu_ready); end
      checks++; if (pending !== 32'h0000_0C00) begin failures++; $display("FAIL full1_pending got=%0h exp=c00", pending); end
      alu_rd = 5'd3; alu_data = XW'(32'h103);
      lsu_rd = 5'd12; lsu_data = XW'(32'hC0);
      tick();
      checks++; if (wnum !== 5'd3 || wd !== XW'(32'h103)) begin failures++; $display("FAIL full2_write got=%0h/%0h exp=3/103", wnum, wd); end
      checks++; if (pending !== 32'h0000_0C00) begin failures++; $display("FAIL full2_pending got=%0h exp=c00", pending); end
      checks++; if (alu_stall !== 1'b0) begin failures++; $display("FAIL full2_stall got=%0h exp=0", alu_stall); end
      idle();
      tick();
      checks++; if (wen !== 1'b1 || wnum !== 5'd10 || wd !== XW'(32'hA0)) begin failures++; $display("FAIL full_pop0 got=%0h/%0h/%0h exp=1/a/a0", wen, wnum, wd); end
      checks++; if (lsu_ready !== 1'b1) begin failures++; $display("FAIL full_pop0_ready got=%0h exp=1", lsu_ready); end
      tick();
      checks++; if (wen !== 1'b1 || wnum !== 5'd11 || wd !== XW'(32'hB0)) begin failures++; $display("FAIL full_pop1 got=%0h/%0h/%0h exp=1/b/b0", wen, wnum, wd); end
      checks++; if (pending !== 32'h0) begin failures++; $display("FAIL full_pop1_pending got=%0h exp=0", pending); end
      tick();
      checks++; if (wen !== 1'b0) begin failures++; $display("FAIL full_drain_wen got=%0h exp=0", wen); end
   endtask

   task automatic test_starve();
      bit exp_stall;
      alu_valid = 1'b1; alu_rd = 5'd1; alu_data = XW'(32'h201);
      lsu_valid = 1'b1; lsu_rd = 5'd20; lsu_data = XW'(32'h2020);
      // Entry is buffered at the first edge; stall expected after the sixth.
      for (int k = 0; k < 6; k++) begin
         alu_rd   = 5'(k + 1);
         alu_data = XW'(32'h200 + k);
         tick();
         lsu_valid = 1'b0;
         exp_stall = (k == 5);
         checks++; if (alu_stall !== exp_stall) begin failures++; $display("FAIL starve_stall k=%0d got=%0h exp=%0h", k, alu_stall, exp_stall); end
         checks++; if (wnum !== 5'(k + 1)) begin failures++; $display("FAIL starve_alu k=%0d got=%0h exp=%0h", k, wnum, k + 1); end
      end
      checks++; if (pending !== 32'h0010_0000) begin failures++; $display("FAIL starve_pending got=%0h exp=100000", pending); end
      idle();
      tick();
      checks++; if (wen !== 1'b1 || wnum !== 5'd20 || wd !== XW'(32'h2020)) begin failures++; $display("FAIL starve_pop got=%0h/%0h/%0h exp=1/14/2020", wen, wnum, wd); end
      checks++; if (alu_stall !== 1'b0) begin failures++; $display("FAIL starve_stall_end got=%0h exp=0", alu_stall); end
      checks++; if (pending !== 32'h0) begin failures++; $display("FAIL starve_pending_end got=%0h exp=0", pending); end
      tick();
   endtask

   task automatic test_async_reset();
      alu_valid = 1'b1; alu_rd = 5'd4; alu_data = XW'(32'h44);
      lsu_valid = 1'b1; lsu_rd = 5'd10; lsu_data = XW'(32'hAA);
      tick();
      alu_rd = 5'd6; lsu_rd = 5'd11; lsu_data = XW'(32'hBB);
      tick();
      checks++; if (wen !== 1'b1 || pending !== 32'h0000_0C00) begin failures++; $display("FAIL arst_pre got wen=%0h pend=%0h exp 1/c00", wen, pending); end
      idle();
      #2;
      rst = 1'b1;
      #1;
      checks++; if (wen !== 1'b0) begin failures++; $display("FAIL arst_wen got=%0h exp=0", wen); end
      checks++; if (pending !== 32'h0) begin failures++; $display("FAIL arst_pending got=%0h exp=0", pending); end
      checks++; if (lsu_ready !== 1'b0) begin failures++; $display("FAIL arst_ready got=%0h exp=0", lsu_ready); end
      tick();
      tick();
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++; if (wen !== 1'b0) begin failures++; $display("FAIL arst_after k=%0d wen got=%0h exp=0", k, wen); end
      end
      checks++; if (lsu_ready !== 1'b1 || pending !== 32'h0) begin failures++; $display("FAIL arst_final got rdy=%0h pend=%0h exp 1/0", lsu_ready, pending); end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      idle();
      test_reset();
      test_alu_only();
      test_x0();
      test_bypass();
      test_collision();
      test_full();
      test_starve();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
